// File: rtl/cache_i_assoc.sv
// cache_i_assoc: set-associative instruction cache between the fetch stage
// and the memory arbiter.
//   clock, reset(active-low, sync), flush : control
//   read, addr -> ready, data             : fetch port (hit data is combinational)
//   ram_read, ram_addr <- ram_busy, ram_ready, ram_data : refill port, one word per read
// On a miss the line is fetched word by word into a buffer, then written
// into the victim way. Victim is the lowest invalid way, otherwise a
// per-set round-robin pointer.
module cache_i_assoc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int WORDS  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic [DATA_W-1:0] data,
  input  logic              ram_busy,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_data,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_addr
);

  localparam int BOFF = $clog2(DATA_W/8);
  localparam int WOFF = $clog2(WORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int OFFW = BOFF + WOFF;
  localparam int TAGW = ADDR_W - OFFW - IDXW;
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int KW   = (WORDS > 1) ? WOFF : 1;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_INSTALL} state_t;

  state_t            r_state;
  logic [KW-1:0]     r_k;
  logic [ADDR_W-1:0] r_base;
  logic [WAYW-1:0]   r_victim;
  logic              r_evict;
  logic              r_kill;
  logic [DATA_W-1:0] r_buf   [WORDS];
  logic [WAYS-1:0]   r_valid [SETS];
  logic [WAYW-1:0]   r_vptr  [SETS];
  logic [TAGW-1:0]   r_tags  [SETS][WAYS];
  logic [DATA_W-1:0] r_lines [SETS][WAYS][WORDS];

  logic [IDXW-1:0]   w_idx;
  logic [TAGW-1:0]   w_tag;
  logic [KW-1:0]     w_woff;
  logic [IDXW-1:0]   w_ridx;
  logic [TAGW-1:0]   w_rtag;
  logic              w_hit;
  logic [WAYW-1:0]   w_hit_way;
  logic              w_inv;
  logic [WAYW-1:0]   w_victim;
  logic              w_ready;
  logic              w_unused;

  assign w_idx    = addr[OFFW +: IDXW];
  assign w_tag    = addr[ADDR_W-1 -: TAGW];
  assign w_woff   = (WORDS > 1) ? addr[BOFF +: KW] : '0;
  assign w_ridx   = r_base[OFFW +: IDXW];
  assign w_rtag   = r_base[ADDR_W-1 -: TAGW];
  assign w_unused = ^addr;

  // Tag compare across the indexed set; first matching valid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tags[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAYW'(w);
      end
    end
  end

  // Lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    w_inv    = 1'b0;
    w_victim = r_vptr[w_idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_inv && !r_valid[w_idx][w]) begin
        w_inv    = 1'b1;
        w_victim = WAYW'(w);
      end
    end
  end

  assign w_ready = reset && !flush && (r_state == S_IDLE) && read && w_hit;
  assign ready   = w_ready;
  assign data    = w_ready ? r_lines[w_idx][w_hit_way][w_woff] : '0;

  // Request is dropped in the ram_ready cycle so only one read is ever outstanding.
  assign ram_read = reset && (r_state == S_REFILL) && !ram_busy && !ram_ready;
  assign ram_addr = (reset && (r_state == S_REFILL)) ?
                    (r_base + (ADDR_W'(r_k) << BOFF)) : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_kill  <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_vptr[s]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (read && !w_hit) begin
            r_state  <= S_REFILL;
            r_base   <= (addr >> OFFW) << OFFW;
            r_victim <= w_victim;
            r_evict  <= !w_inv;
            r_k      <= '0;
            r_kill   <= 1'b0;
          end
        end
        S_REFILL: begin
          // A flush mid-refill lets the refill finish but blocks the install.
          if (flush) r_kill <= 1'b1;
          if (ram_ready) begin
            r_buf[r_k] <= ram_data;
            r_k        <= r_k + 1'b1;
            if (r_k == KW'(WORDS-1)) r_state <= S_INSTALL;
          end
        end
        S_INSTALL: begin
          r_state <= S_IDLE;
          if (!flush && !r_kill) begin
            r_valid[w_ridx][r_victim] <= 1'b1;
            r_tags[w_ridx][r_victim]  <= w_rtag;
            for (int unsigned i = 0; i < WORDS; i++)
              r_lines[w_ridx][r_victim][i] <= r_buf[i];
            if (r_evict)
              r_vptr[w_ridx] <= (r_vptr[w_ridx] == WAYW'(WAYS-1)) ?
                                '0 : r_vptr[w_ridx] + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (flush) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          r_valid[s] <= '0;
          r_vptr[s]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_i_assoc.sv
// Scoreboard bench for cache_i_assoc (WAYS=2, SETS=64, WORDS=4).
// Stimulus pushes expected memory addresses and fetch data into queues;
// a negedge monitor pops them whenever the DUT issues ram_read or ready.
module tb_cache_i_assoc;

  logic        clock = 1'b0;
  logic        reset, flush, read;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] data;
  logic        ram_busy, ram_ready;
  logic [31:0] ram_data;
  logic        ram_read;
  logic [31:0] ram_addr;

  always #5 clock = ~clock;

  cache_i_assoc #(
    .ADDR_W(32), .DATA_W(32), .SETS(64), .WAYS(2), .WORDS(4)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .read(read), .addr(addr),
    .ready(ready), .data(data), .ram_busy(ram_busy), .ram_ready(ram_ready),
    .ram_data(ram_data), .ram_read(ram_read), .ram_addr(ram_addr)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] q_raddr[$];
  logic [31:0] q_data[$];

  // memory model state (owned by the memory process, except the trigger setup)
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          busy_left = 0;
  bit          busy_fired = 1'b0;
  bit          busy_trig;
  logic [31:0] busy_trig_addr, busy_exp_addr;

  // mid-fetch injection: after inj_left ram_ready pulses, 1=flush / 2=reset for one cycle
  int inj_mode = 0;
  int inj_left = 0;
  int arm      = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'hF;
    for (int i = 0; i < 4; i++) q_raddr.push_back(base + 32'(4*i));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0; read = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Holds read until ready and checks cycles from the first read cycle to ready.
  task automatic fetch(input logic [31:0] a, input bit miss, input int exp_lat, input string name);
    int lat;
    if (miss) push_line(a);
    q_data.push_back(memf(a));
    read = 1'b1;
    addr = a;
    lat  = 0;
    @(negedge clock);
    while (!ready && lat < 200) begin
      if (inj_mode != 0 && inj_left > 0 && ram_ready) begin
        inj_left--;
        if (inj_left == 0) arm = 1;
      end
      @(posedge clock); #1;
      if (arm == 1) begin
        if (inj_mode == 1) flush = 1'b1; else reset = 1'b0;
        arm = 2;
      end else if (arm == 2) begin
        flush = 1'b0; reset = 1'b1;
        arm = 0; inj_mode = 0;
      end
      @(negedge clock);
      lat++;
    end
    if (!ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no ready expected ready after %0d cycles", name, exp_lat);
    end else begin
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    end
    @(posedge clock); #1;
    read = 1'b0;
  endtask

  // memory: answers each accepted read with a one-cycle ram_ready on the next cycle
  initial begin
    ram_ready = 1'b0; ram_busy = 1'b0; ram_data = '0;
    forever begin
      @(posedge clock); #2;
      ram_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (pend) begin
        ram_ready = 1'b1;
        ram_data  = memf(pend_addr);
        pend      = 1'b0;
        if (busy_trig && !busy_fired && pend_addr == busy_trig_addr) begin
          busy_fired = 1'b1;
          busy_left  = 5;
        end
      end else begin
        ram_ready = 1'b0;
        ram_data  = 32'hDEAD_BEEF;
      end
      @(negedge clock);
      if (ram_read) begin
        pend      = 1'b1;
        pend_addr = ram_addr;
      end
    end
  end

  // monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("reset_outputs", {ready, ram_read, 30'b0}, 32'h0);
        check("reset_data", data, 32'h0);
        check("reset_ram_addr", ram_addr, 32'h0);
      end
      if (flush) check("flush_ready", {31'b0, ready}, 32'h0);
      if (ram_busy) begin
        check("busy_ram_read", {31'b0, ram_read}, 32'h0);
        check("busy_ram_addr", ram_addr, busy_exp_addr);
      end
      if (ram_read) begin
        if (q_raddr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ram_read_unexpected: got request addr %h expected no request", ram_addr);
        end else begin
          e = q_raddr.pop_front();
          check("ram_addr", ram_addr, e);
        end
      end
      if (ready) begin
        if (q_data.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ready_unexpected: got ready data %h expected no ready", data);
        end else begin
          e = q_data.pop_front();
          check("data", data, e);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0; flush = 1'b0; read = 1'b0; addr = '0;
    busy_trig = 1'b0; busy_trig_addr = '0; busy_exp_addr = '0;

    // 1: cold miss then hit in the same line
    do_reset();
    fetch(32'h1008, 1, 10, "t1_cold");
    fetch(32'h100C, 0, 0,  "t1_hit");

    // 2: three lines in set 0, round-robin eviction
    do_reset();
    fetch(32'h0004, 1, 10, "t2_a");
    fetch(32'h0408, 1, 10, "t2_b");
    fetch(32'h080C, 1, 10, "t2_c_evicts_a");
    fetch(32'h0400, 0, 0,  "t2_b_hit");
    fetch(32'h0000, 1, 10, "t2_a_evicts_b");
    fetch(32'h0800, 0, 0,  "t2_c_hit");
    fetch(32'h0404, 1, 10, "t2_b_missed");

    // 3: memory busy for 5 cycles while word 2 is pending
    do_reset();
    busy_trig_addr = 32'h2004;
    busy_exp_addr  = 32'h2008;
    busy_trig      = 1'b1;
    fetch(32'h2000, 1, 15, "t3_busy");
    check("t3_busy_seen", {31'b0, busy_fired}, 32'h1);
    fetch(32'h2008, 0, 0, "t3_hit_w2");

    // 4: flush after fill, then flush in the INSTALL cycle
    do_reset();
    fetch(32'h3004, 1, 10, "t4_fill0");
    fetch(32'h3014, 1, 10, "t4_fill1");
    fetch(32'h3000, 0, 0,  "t4_hit0");
    fetch(32'h3010, 0, 0,  "t4_hit1");
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    fetch(32'h3004, 1, 10, "t4_refetch0");
    fetch(32'h3014, 1, 10, "t4_refetch1");
    push_line(32'h3020);
    inj_mode = 1; inj_left = 4;
    fetch(32'h3020, 1, 20, "t4_flush_install");
    fetch(32'h3024, 0, 0,  "t4_after_hit");

    // 5: reset after word 1 aborts the refill
    do_reset();
    q_raddr.push_back(32'h4000);
    q_raddr.push_back(32'h4004);
    inj_mode = 2; inj_left = 2;
    fetch(32'h4008, 1, 16, "t5_reset_mid");
    fetch(32'h400C, 0, 0,  "t5_hit");

    // 6: read dropped after word 0; line still installs
    do_reset();
    push_line(32'h5004);
    read = 1'b1; addr = 32'h5004;
    n = 0;
    @(negedge clock);
    while (!ram_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("t6_word0_seen", {31'b0, ram_ready}, 32'h1);
    @(posedge clock); #1;
    read = 1'b0; addr = 32'h9990;
    repeat (12) @(posedge clock);
    #1;
    fetch(32'h5004, 0, 0, "t6_hit");
    fetch(32'h500C, 0, 0, "t6_hit_w3");

    repeat (4) @(posedge clock);
    check("raddr_queue_empty", 32'(q_raddr.size()), 32'h0);
    check("data_queue_empty", 32'(q_data.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
